// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default halt word / watchdog limit, and a saturating counter helper.
package fetch_unit_pkg;

    // Legacy-compatible state encodings; the enum below is built on them.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_MEM = 3'd2;
    localparam logic [2:0] ST_ISSUE    = 3'd3;
    localparam logic [2:0] ST_EXEC     = 3'd4;
    localparam logic [2:0] ST_HALT     = 3'd5;
    localparam logic [2:0] ST_ERROR    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_FETCH    = ST_FETCH,
        S_WAIT_MEM = ST_WAIT_MEM,
        S_ISSUE    = ST_ISSUE,
        S_EXEC     = ST_EXEC,
        S_HALT     = ST_HALT,
        S_ERROR    = ST_ERROR
    } fetch_state_e;

    localparam logic [15:0] DEFAULT_HALT_INSTR = 16'hFFFF;
    localparam int          DEFAULT_TIMEOUT    = 255;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Loadable saturating up-counter. terminal is high while the count sits at
// LIMIT; the counter then stops advancing until it is reloaded.
module fetch_watchdog #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 254
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_reg;

    // Load has priority over counting; counting stops at LIMIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != LIMIT_V)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign terminal = (count_reg == LIMIT_V);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/issue sequencer for the bitty core: reads a word from
// instruction memory, issues it with a one-cycle run pulse, waits for done,
// and stops on the halt word or when the execution watchdog expires.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter logic [15:0] HALT_INSTR = DEFAULT_HALT_INSTR,
    parameter int          TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       d_instr,
    output logic              run,
    input  logic              done,
    input  logic [15:0]       d_out,
    output logic [15:0]       last_result,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              halted,
    output logic              timeout_err
);

    // The watchdog only has to reach TIMEOUT-1 (the TIMEOUT-th idle cycle).
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    fetch_state_e      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [15:0]       d_instr_reg;
    logic [15:0]       last_result_reg;
    logic [15:0]       instr_count_reg;

    logic wd_load;
    logic wd_enable;
    logic wd_terminal;

    assign wd_load   = (state_reg == S_ISSUE);
    assign wd_enable = (state_reg == S_EXEC) && !done;

    fetch_watchdog #(
        .WIDTH (WD_W),
        .LIMIT (TIMEOUT - 1)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .load       (wd_load),
        .load_value ('0),
        .enable     (wd_enable),
        .terminal   (wd_terminal)
    );

    // Main sequencer: state, program counter, instruction and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            pc_reg          <= '0;
            d_instr_reg     <= 16'h0000;
            last_result_reg <= 16'h0000;
            instr_count_reg <= 16'h0000;
        end else begin
            case (state_reg)
                // HALT and ERROR freeze everything but restart exactly like IDLE.
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        pc_reg          <= '0;
                        instr_count_reg <= 16'h0000;
                        state_reg       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_reg <= S_WAIT_MEM;
                end
                S_WAIT_MEM: begin
                    // The halt word is never latched or issued.
                    if (imem_rdata == HALT_INSTR) begin
                        state_reg <= S_HALT;
                    end else begin
                        d_instr_reg <= imem_rdata;
                        state_reg   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    // done wins over a watchdog expiry in the same cycle.
                    if (done) begin
                        last_result_reg <= d_out;
                        instr_count_reg <= sat_inc16(instr_count_reg);
                        pc_reg          <= pc_reg + ADDR_W'(1);
                        state_reg       <= S_FETCH;
                    end else if (wd_terminal) begin
                        state_reg <= S_ERROR;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_addr   = pc_reg;
    assign imem_rd_en  = (state_reg == S_FETCH);
    assign run         = (state_reg == S_ISSUE);
    assign d_instr     = d_instr_reg;
    assign last_result = last_result_reg;
    assign pc          = pc_reg;
    assign instr_count = instr_count_reg;
    assign halted      = (state_reg == S_HALT);
    assign timeout_err = (state_reg == S_ERROR);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an 8-bit-address instance with a
// programmable bitty responder, plus a 2-bit-address instance for pc wrap.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- main instance (ADDR_W = 8) ----------------
    logic        reset, start, man_done, auto_en;
    int          dly;
    logic [15:0] dout_val;
    logic [7:0]  imem_addr, pc;
    logic        imem_rd_en, run, halted, timeout_err, done, model_done;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] d_instr, last_result, instr_count, d_out;
    logic [15:0] mem [256];
    int          wcnt = 0;
    logic [15:0] run_q[$];
    int          overlap = 0;

    assign model_done = auto_en && (wcnt == 1);
    assign done       = man_done | model_done;
    assign d_out      = dout_val;

    fetch_unit #(.ADDR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_rdata  (imem_rdata),
        .d_instr     (d_instr),
        .run         (run),
        .done        (done),
        .d_out       (d_out),
        .last_result (last_result),
        .pc          (pc),
        .instr_count (instr_count),
        .halted      (halted),
        .timeout_err (timeout_err)
    );

    // Synchronous instruction memory: data valid the cycle after rd_en.
    always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

    // Bitty responder: done arrives dly cycles after the run pulse.
    always @(posedge clk) begin
        if (run && auto_en) wcnt <= dly;
        else if (wcnt != 0) wcnt <= wcnt - 1;
    end

    always @(negedge clk) begin
        if (run) run_q.push_back(d_instr);
        if (run && imem_rd_en) overlap++;
    end

    // ---------------- wrap instance (ADDR_W = 2) ----------------
    logic        start2, done2, rd_en2, run2, halted2, terr2;
    logic [1:0]  addr2, pc2;
    logic [15:0] rdata2 = 16'h0000;
    logic [15:0] d_instr2, last2, count2;
    logic [15:0] mem2 [4];
    int          cyc = 0;
    int          pc2_q[$];
    int          cnt2_q[$];
    int          cyc2_q[$];

    assign done2 = 1'b1;

    fetch_unit #(.ADDR_W(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .start       (start2),
        .imem_addr   (addr2),
        .imem_rd_en  (rd_en2),
        .imem_rdata  (rdata2),
        .d_instr     (d_instr2),
        .run         (run2),
        .done        (done2),
        .d_out       (16'h0055),
        .last_result (last2),
        .pc          (pc2),
        .instr_count (count2),
        .halted      (halted2),
        .timeout_err (terr2)
    );

    always @(posedge clk) if (rd_en2) rdata2 <= mem2[addr2];

    always @(negedge clk) begin
        cyc++;
        if (rd_en2) begin
            pc2_q.push_back(int'(pc2));
            cnt2_q.push_back(int'(count2));
            cyc2_q.push_back(cyc);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%h", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_q.delete();
    endtask

    // Returns at the negedge of the FETCH cycle.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge of the ISSUE cycle (run high).
    task automatic wait_run(input string tag);
        int n = 0;
        while (!run && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(run), 32'd1);
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; start2 = 1'b0; man_done = 1'b0;
        auto_en = 1'b0; dly = 2; dout_val = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        mem2[0] = 16'h0101; mem2[1] = 16'h0202; mem2[2] = 16'h0303; mem2[3] = 16'h0404;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_pc",          32'(pc),          32'd0);
        check("rst_d_instr",     32'(d_instr),     32'd0);
        check("rst_last_result", 32'(last_result), 32'd0);
        check("rst_instr_count", 32'(instr_count), 32'd0);
        check("rst_run",         32'(run),         32'd0);
        check("rst_rd_en",       32'(imem_rd_en),  32'd0);
        check("rst_addr",        32'(imem_addr),   32'd0);
        check("rst_halted",      32'(halted),      32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b1;

        // Three-word program ending in the halt word, done 2 cycles after run
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hFFFF;
        auto_en = 1'b1; dly = 2; dout_val = 16'h00AA;
        run_q.delete();
        pulse_start();
        wait_halt("prog_halted");
        check("prog_runs",   32'(run_q.size()), 32'd2);
        check("prog_run0",   32'(run_q.size() > 0 ? run_q[0] : 16'h0), 32'h1234);
        check("prog_run1",   32'(run_q.size() > 1 ? run_q[1] : 16'h0), 32'h5678);
        check("prog_count",  32'(instr_count), 32'd2);
        check("prog_pc",     32'(pc),          32'd2);
        check("prog_result", 32'(last_result), 32'h00AA);
        check("prog_instr",  32'(d_instr),     32'h5678);

        // Watchdog: done never returns
        do_reset();
        auto_en = 1'b0; mem[0] = 16'h1111; mem[1] = 16'hFFFF;
        pulse_start();
        wait_run("wd_run");
        n = 0;
        while (!timeout_err && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("wd_cycles",      32'(n),           32'd256);
        check("wd_timeout_err", 32'(timeout_err), 32'd1);
        check("wd_result",      32'(last_result), 32'd0);
        check("wd_pc",          32'(pc),          32'd0);
        pulse_start();
        check("err_restart_rd", 32'(imem_rd_en),  32'd1);
        check("err_restart_te", 32'(timeout_err), 32'd0);

        // done coincident with watchdog expiry
        do_reset();
        mem[0] = 16'h4444; mem[1] = 16'hFFFF;
        pulse_start();
        wait_run("race_run");
        repeat (255) @(negedge clk);
        check("race_pre_te", 32'(timeout_err), 32'd0);
        man_done = 1'b1; dout_val = 16'hBEEF;
        @(negedge clk);
        man_done = 1'b0;
        check("race_fetch",  32'(imem_rd_en),  32'd1);
        check("race_te",     32'(timeout_err), 32'd0);
        check("race_result", 32'(last_result), 32'hBEEF);
        check("race_count",  32'(instr_count), 32'd1);
        check("race_addr",   32'(imem_addr),   32'd1);

        // Reset mid-EXEC, then a late done
        do_reset();
        mem[0] = 16'h1357; mem[1] = 16'hFFFF; dout_val = 16'hCAFE;
        pulse_start();
        wait_run("mid_run");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_async_instr", 32'(d_instr), 32'd0);
        check("mid_async_run",   32'(run),     32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_result", 32'(last_result), 32'd0);
        check("mid_count",  32'(instr_count), 32'd0);
        check("mid_pc",     32'(pc),          32'd0);
        check("mid_rd_en",  32'(imem_rd_en),  32'd0);
        check("mid_halted", 32'(halted),      32'd0);

        // Stray done in IDLE and FETCH, start during EXEC
        mem[0] = 16'h2468; mem[1] = 16'hFFFF; dout_val = 16'h1111;
        run_q.delete();
        pulse_start();
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("stray_fetch_count", 32'(instr_count), 32'd0);
        wait_run("stray_run");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("exec_start_rd_en", 32'(imem_rd_en),  32'd0);
        check("exec_start_run",   32'(run),         32'd0);
        check("exec_start_count", 32'(instr_count), 32'd0);
        check("exec_start_instr", 32'(d_instr),     32'h2468);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("exec_done_count",  32'(instr_count), 32'd1);
        check("exec_done_pc",     32'(pc),          32'd1);
        check("exec_done_result", 32'(last_result), 32'h1111);
        wait_halt("stray_halted");
        check("stray_runs", 32'(run_q.size()), 32'd1);

        // pc wrap on the 2-bit instance, done always high
        do_reset();
        pc2_q.delete(); cnt2_q.delete(); cyc2_q.delete();
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (pc2_q.size() < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wrap_fetches", 32'(pc2_q.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++)
            check($sformatf("wrap_pc%0d", i), 32'(pc2_q.size() > i ? pc2_q[i] : -1), 32'(i % 4));
        check("wrap_count", 32'(cnt2_q.size() > 4 ? cnt2_q[4] : -1), 32'd4);
        check("fetch_spacing", 32'(cyc2_q.size() > 1 ? cyc2_q[1] - cyc2_q[0] : -1), 32'd4);

        check("no_rd_run_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 Parameter HALT_INSTR, default 16'hFFFF, instruction word that stops fetching.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles to wait for done.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin fetching from address 0; sampled only in IDLE.
REQ-007 imem_addr  out  ADDR_W  instruction-memory read address.
REQ-008 imem_rd_en  out  1  read strobe; imem_rdata is valid exactly one cycle later.
REQ-009 imem_rdata  in  16  instruction-memory read data.
REQ-010 d_instr  out  16  instruction presented to the downstream bitty core.
REQ-011 run  out  1  one-cycle issue pulse to the bitty core.
REQ-012 done  in  1  bitty completion pulse.
REQ-013 d_out  in  16  bitty result bus, sampled when done is high.
REQ-014 last_result  out  16  most recently captured d_out.
REQ-015 pc  out  ADDR_W  address of the current or next instruction.
REQ-016 instr_count  out  16  instructions completed since start; saturates at 16'hFFFF.
REQ-017 halted  out  1  high in HALT state.
REQ-018 timeout_err  out  1  high in ERROR state.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, HALT, ERROR.
REQ-020 IDLE: start=1 -> pc<=0, instr_count<=0, go to FETCH; otherwise stay in IDLE.
REQ-021 FETCH: imem_rd_en=1 and imem_addr=pc for exactly one cycle; go to WAIT_MEM.
REQ-022 WAIT_MEM: capture imem_rdata; if it equals HALT_INSTR, go to HALT, else latch it into d_instr and go to ISSUE.
REQ-023 ISSUE: run=1 for exactly one cycle; clear the watchdog counter; go to EXEC.
REQ-024 EXEC: d_instr SHALL hold stable; done=1 -> last_result<=d_out, instr_count+1 (saturating), pc+1, go to FETCH.
REQ-025 In EXEC, a watchdog counter increments each cycle done is low; reaching TIMEOUT -> ERROR.
REQ-026 The minimum fetch-to-next-fetch cost SHALL be 4 cycles: FETCH, WAIT_MEM, ISSUE, and one EXEC cycle with done.
REQ-027 pc SHALL wrap from 2**ADDR_W-1 to 0 with no flag.
REQ-028 done outside EXEC SHALL be ignored.
REQ-029 done in the same cycle as a watchdog expiry SHALL take priority, so the instruction completes.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 HALT and ERROR hold all outputs and leave only on reset, or on start, which behaves as in IDLE.
REQ-032 The HALT_INSTR word SHALL never be issued and SHALL NOT increment pc or instr_count.
REQ-033 imem_rd_en and run SHALL never be high in the same cycle.

Reset
REQ-034 reset low SHALL force IDLE immediately, asynchronously, regardless of clk.
REQ-035 Reset values: pc=0, d_instr=16'h0000, last_result=16'h0000, instr_count=0, run=0, imem_rd_en=0, imem_addr=0, halted=0, timeout_err=0, watchdog=0.
REQ-036 Reset mid-EXEC SHALL drop run and abandon the instruction; a later done SHALL be ignored.

Structure
REQ-037 The shared package holds the state enum, the default HALT_INSTR and the default TIMEOUT.
REQ-038 The block is one module plus one sub-module, fetch_watchdog, a loadable saturating counter with a terminal-count output.
REQ-039 The top level connects d_instr, run, done and d_out directly to the bitty ports of the same names.

Verification
REQ-040 Program {0x1234, 0x5678, 0xFFFF} with done returned 2 cycles after run: two run pulses with d_instr 0x1234 then 0x5678; halted=1; instr_count=2; pc=2.
REQ-041 Done held low for 255 EXEC cycles: timeout_err=1; last_result unchanged; pc unchanged.
REQ-042 ADDR_W=2, four non-halt words, done immediate: pc sequence 0,1,2,3,0; instr_count=4 after the first wrap.
REQ-043 Reset driven low mid-EXEC, then done pulsed: state IDLE, all outputs at reset values, done has no effect.
REQ-044 Stray done in IDLE and in FETCH, plus start pulsed during EXEC: no state change, no count change.
REQ-045 done and watchdog expiry in the same cycle with d_out=0xBEEF: last_result=0xBEEF, state FETCH, timeout_err=0.
